// File: rtl/core_s1_fetch.sv
// Stage-1 instruction fetch: owns the PC, keeps one icache request in flight and
// buffers the returned word for decode. Redirects flush the buffer and retire stale responses.
module core_s1_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        o_ic_req_valid,
  input  logic        i_ic_req_ready,
  output logic [31:0] o_ic_req_addr,
  input  logic        i_ic_rsp_valid,
  input  logic [31:0] i_ic_rsp_instr,
  input  logic        i_ic_rsp_fault,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_s2_valid,
  input  logic        i_s2_ready,
  output logic [31:0] o_s2_pc,
  output logic [31:0] o_s2_instr,
  output logic        o_s2_fault
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_s2_valid;
  logic [31:0] r_s2_pc;
  logic [31:0] r_s2_instr;
  logic        r_s2_fault;

  logic        w_issue;
  logic        w_hs;

  // Only issue when the buffer is empty or draining now, so a response always finds room.
  assign w_issue        = (r_state == S_FETCH) && (!r_s2_valid || i_s2_ready);
  assign w_hs           = w_issue && i_ic_req_ready;
  assign o_ic_req_valid = w_issue;
  assign o_ic_req_addr  = r_pc;
  assign o_s2_valid     = r_s2_valid;
  assign o_s2_pc        = r_s2_pc;
  assign o_s2_instr     = r_s2_instr;
  assign o_s2_fault     = r_s2_fault;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_s2_valid <= 1'b0;
      r_s2_pc    <= 32'h0;
      r_s2_instr <= 32'h0;
      r_s2_fault <= 1'b0;
    end else if (i_redirect_valid) begin
      r_pc       <= i_redirect_pc & ~32'h3;
      r_s2_valid <= 1'b0;
      // A request the cache already accepted must have its response swallowed in DROP.
      case (r_state)
        S_FETCH:        r_state <= w_hs ? S_DROP : S_FETCH;
        S_WAIT, S_DROP: r_state <= i_ic_rsp_valid ? S_FETCH : S_DROP;
        default:        r_state <= S_FETCH;
      endcase
    end else begin
      if (r_s2_valid && i_s2_ready) r_s2_valid <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (w_hs) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_ic_rsp_valid) begin
            r_s2_valid <= 1'b1;
            r_s2_pc    <= r_pc;
            r_s2_fault <= i_ic_rsp_fault;
            r_s2_instr <= i_ic_rsp_fault ? 32'h0 : i_ic_rsp_instr;
            if (i_ic_rsp_fault) begin
              r_state <= S_HALT;
            end else begin
              r_pc    <= r_pc + 32'd4;
              r_state <= S_FETCH;
            end
          end
        end
        S_DROP: begin
          if (i_ic_rsp_valid) r_state <= S_FETCH;
        end
        default: begin
        end
      endcase
    end
  end

  // The icache only answers requests it accepted, so a response with none outstanding is a bug.
  a_rsp_only_when_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n)
    i_ic_rsp_valid |-> (r_state == S_WAIT || r_state == S_DROP)
  );

endmodule

// File: tb/tb_core_s1_fetch.sv
// Self-checking bench for core_s1_fetch: an icache model answers handshakes after a set
// latency, and a scoreboard of expected decode entries is checked when decode consumes.
module tb_core_s1_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        o_ic_req_valid;
  logic        i_ic_req_ready;
  logic [31:0] o_ic_req_addr;
  logic        i_ic_rsp_valid;
  logic [31:0] i_ic_rsp_instr;
  logic        i_ic_rsp_fault;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic        o_s2_valid;
  logic        i_s2_ready;
  logic [31:0] o_s2_pc;
  logic [31:0] o_s2_instr;
  logic        o_s2_fault;

  always #5 clk = ~clk;

  core_s1_fetch #(.RESET_PC(RST_PC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .o_ic_req_valid   (o_ic_req_valid),
    .i_ic_req_ready   (i_ic_req_ready),
    .o_ic_req_addr    (o_ic_req_addr),
    .i_ic_rsp_valid   (i_ic_rsp_valid),
    .i_ic_rsp_instr   (i_ic_rsp_instr),
    .i_ic_rsp_fault   (i_ic_rsp_fault),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_s2_valid       (o_s2_valid),
    .i_s2_ready       (i_s2_ready),
    .o_s2_pc          (o_s2_pc),
    .o_s2_instr       (o_s2_instr),
    .o_s2_fault       (o_s2_fault)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          n_take  = 0;
  int          last_take = -1;
  bit          chk_gap = 1'b0;
  exp_t        sb[$];

  // Reference model state: next fetch PC and the icache's single outstanding request.
  logic [31:0] m_pc = RST_PC;
  bit          pend = 1'b0;
  bit          pend_stale = 1'b0;
  logic [31:0] pend_pc = 32'h0;
  int          pend_cnt = 0;
  int          rsp_delay = 1;
  bit          fault_en = 1'b0;
  logic [31:0] fault_pc = 32'h0;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0], 16'h0013} ^ 32'h5a5a_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: sample at negedge, then advance to just after posedge and drive the icache.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (o_s2_valid && i_s2_ready) begin
      if (sb.size() == 0) begin
        check("s2_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("s2_pc", o_s2_pc, e.pc);
        check("s2_instr", o_s2_instr, e.instr);
        check("s2_fault", {31'h0, o_s2_fault}, {31'h0, e.fault});
        if (chk_gap && last_take >= 0) check("s2_gap", cyc - last_take, 32'd2);
        last_take = cyc;
        n_take++;
      end
    end
    if (i_ic_rsp_valid) begin
      if (!pend_stale && !i_redirect_valid) begin
        if (i_ic_rsp_fault) begin
          sb.push_back(exp_t'{pc: pend_pc, instr: 32'h0, fault: 1'b1});
        end else begin
          sb.push_back(exp_t'{pc: pend_pc, instr: instr_of(pend_pc), fault: 1'b0});
          m_pc = m_pc + 32'd4;
        end
      end
      pend = 1'b0;
    end
    if (o_ic_req_valid && i_ic_req_ready) begin
      check("req_addr", o_ic_req_addr, m_pc);
      pend       = 1'b1;
      pend_pc    = m_pc;
      pend_cnt   = rsp_delay;
      pend_stale = i_redirect_valid;
    end else if (i_redirect_valid) begin
      pend_stale = 1'b1;
    end
    if (i_redirect_valid) begin
      sb.delete();
      m_pc = i_redirect_pc & ~32'h3;
    end
    @(posedge clk);
    #1;
    cyc++;
    i_ic_rsp_valid = 1'b0;
    i_ic_rsp_instr = 32'h0;
    i_ic_rsp_fault = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        i_ic_rsp_valid = 1'b1;
        i_ic_rsp_instr = instr_of(pend_pc);
        i_ic_rsp_fault = fault_en && (pend_pc == fault_pc);
      end
    end
  endtask

  task automatic redirect(input logic [31:0] pc);
    i_redirect_valid = 1'b1;
    i_redirect_pc    = pc;
    cycle();
    i_redirect_valid = 1'b0;
    i_redirect_pc    = 32'h0;
  endtask

  task automatic wait_req(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_ic_req_valid) begin
        seen = 1'b1;
        break;
      end
      cycle();
    end
    if (!seen) check(tag, 32'd0, 32'd1);
  endtask

  initial begin
    bit ok;
    rst_n            = 1'b0;
    i_ic_req_ready   = 1'b0;
    i_ic_rsp_valid   = 1'b0;
    i_ic_rsp_instr   = 32'h0;
    i_ic_rsp_fault   = 1'b0;
    i_redirect_valid = 1'b0;
    i_redirect_pc    = 32'h0;
    i_s2_ready       = 1'b0;

    // Reset state held, then stable across release
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s2_valid", {31'h0, o_s2_valid}, 32'd0);
    check("rst_s2_pc", o_s2_pc, 32'h0);
    check("rst_s2_instr", o_s2_instr, 32'h0);
    check("rst_s2_fault", {31'h0, o_s2_fault}, 32'd0);
    check("rst_req_valid", {31'h0, o_ic_req_valid}, 32'd1);
    check("rst_req_addr", o_ic_req_addr, RST_PC);
    @(posedge clk);
    #3 rst_n = 1'b1;
    cycle();
    cycle();
    check("post_rst_req_valid", {31'h0, o_ic_req_valid}, 32'd1);
    check("post_rst_req_addr", o_ic_req_addr, RST_PC);
    check("post_rst_s2_valid", {31'h0, o_s2_valid}, 32'd0);

    // Streaming: one instruction every 2 cycles
    i_ic_req_ready = 1'b1;
    i_s2_ready     = 1'b1;
    chk_gap        = 1'b1;
    for (int i = 0; i < 20 && n_take < 3; i++) cycle();
    check("t2_count", n_take, 32'd3);
    chk_gap = 1'b0;

    // Decode stall with a full buffer
    i_s2_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (o_s2_valid && !pend) begin
        ok = 1'b1;
        break;
      end
      cycle();
    end
    check("t3_fill", {31'h0, ok}, 32'd1);
    check("t3_sb_one", sb.size(), 32'd1);
    if (sb.size() == 1) begin
      for (int i = 0; i < 5; i++) begin
        check("t3_no_req", {31'h0, o_ic_req_valid}, 32'd0);
        check("t3_hold_pc", o_s2_pc, sb[0].pc);
        check("t3_hold_instr", o_s2_instr, sb[0].instr);
        cycle();
      end
    end
    i_s2_ready = 1'b1;
    #1;
    check("t3_release_req", {31'h0, o_ic_req_valid}, 32'd1);

    // Redirect while a request is outstanding; stale response two cycles later
    rsp_delay = 3;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (pend && pend_cnt == 2) begin
        ok = 1'b1;
        break;
      end
    end
    check("t4_in_wait", {31'h0, ok}, 32'd1);
    redirect(32'h0000_1002);
    check("t4_flushed", {31'h0, o_s2_valid}, 32'd0);
    check("t4_no_req", {31'h0, o_ic_req_valid}, 32'd0);
    rsp_delay = 1;
    wait_req("t4_timeout");
    check("t4_addr", o_ic_req_addr, 32'h0000_1000);

    // Redirect coinciding with a request handshake
    rsp_delay = 2;
    wait_req("t5_timeout");
    redirect(32'h0000_2000);
    check("t5_drop_no_req", {31'h0, o_ic_req_valid}, 32'd0);
    rsp_delay = 1;
    wait_req("t5_timeout2");
    check("t5_addr", o_ic_req_addr, 32'h0000_2000);
    for (int i = 0; i < 4; i++) cycle();

    // Fault halts fetch until a redirect
    fault_en   = 1'b1;
    fault_pc   = 32'h0000_0040;
    i_s2_ready = 1'b0;
    redirect(32'h0000_0040);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (o_s2_valid) begin
        ok = 1'b1;
        break;
      end
      cycle();
    end
    check("t6_loaded", {31'h0, ok}, 32'd1);
    check("t6_fault", {31'h0, o_s2_fault}, 32'd1);
    check("t6_pc", o_s2_pc, 32'h0000_0040);
    check("t6_instr", o_s2_instr, 32'h0);
    for (int i = 0; i < 10; i++) begin
      check("t6_halt_no_req", {31'h0, o_ic_req_valid}, 32'd0);
      cycle();
    end
    i_s2_ready = 1'b1;
    cycle();
    check("t6_still_halt", {31'h0, o_ic_req_valid}, 32'd0);
    fault_en = 1'b0;
    redirect(32'h0000_0100);
    check("t6_restart_req", {31'h0, o_ic_req_valid}, 32'd1);
    check("t6_restart_addr", o_ic_req_addr, 32'h0000_0100);
    for (int i = 0; i < 6; i++) cycle();

    // Drain
    i_ic_req_ready = 1'b0;
    for (int i = 0; i < 10 && (pend || sb.size() != 0 || o_s2_valid); i++) cycle();
    check("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
